// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle between a streaming producer/consumer pair and
// the single-clock FIFO controller. The master side drives requests; the
// slave (the FIFO) drives data and status back.
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
);

  // Control and write side
  logic                  flush;
  logic                  clr_err;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;

  // Read data and status
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, w_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, clr_err, w_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with fill count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and a
// selectable registered or first-word-fall-through read port.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_ctrl_if.slave    bus
);

  // Parameter sanity checks resolved at elaboration.
  if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
    $error("sync_fifo_ctrl: DEPTH must equal 2**PTR_WIDTH");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_ctrl: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ctrl: AE_LEVEL out of range 0..DEPTH-1");
  end

  localparam logic [PTR_WIDTH:0] AF_THRESH = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_THRESH = (PTR_WIDTH+1)'(AE_LEVEL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_WIDTH:0]    wptr_q, wptr_d;
  logic [PTR_WIDTH:0]    rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0]  waddr;
  logic [PTR_WIDTH-1:0]  raddr;
  logic [PTR_WIDTH:0]    count;
  logic                  full;
  logic                  empty;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  mem_we;

  assign waddr = wptr_q[PTR_WIDTH-1:0];
  assign raddr = rptr_q[PTR_WIDTH-1:0];

  // Status decoded from registered pointers only, so no input reaches an
  // output through combinational logic (apart from the FWFT data mux).
  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                 (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);

  assign wr_fire = bus.w_en && !full;
  assign rd_fire = bus.r_en && !empty;

  // A flush (or reset) in the same cycle discards the write entirely.
  assign mem_we  = wr_fire && !bus.flush && !rst;

  // Next-state for pointers, read register and sticky error flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      dout_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_fire) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_fire) begin
        rptr_d = rptr_q + 1'b1;
        dout_d = mem_q[raddr];
      end
      // Clear first so a coincident error event wins over clr_err.
      if (bus.clr_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (bus.w_en && full) begin
        overflow_d = 1'b1;
      end
      if (bus.r_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control state register with synchronous reset taking top priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; only pointers define
    // which entries are valid, and this lets it map onto RAM.
    if (mem_we) begin
      mem_q[waddr] <= bus.data_in;
    end
  end

  // In FWFT mode the head entry is presented directly; otherwise the
  // registered copy captured on each accepted read.
  assign bus.data_out     = (FWFT != 0) ? mem_q[raddr] : dout_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_THRESH);
  assign bus.almost_empty = (count <= AE_THRESH);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: a table of directed vectors for the
// fill/drain/error sequence on a registered-read instance, then hand-written
// sequences for wrap, streaming, flush and fall-through behaviour.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .PTR_WIDTH(3)) bus0 ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .PTR_WIDTH(3)) bus1 ();

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .PTR_WIDTH(3), .DEPTH(8),
    .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .PTR_WIDTH(3), .DEPTH(8),
    .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic       w_en;
    logic       r_en;
    logic       clr_err;
    logic [7:0] din;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic [7:0] dout;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [21];
  logic [7:0] model_q [$];
  logic [7:0] exp_d;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic ce,
                              input logic [7:0] din, input logic [3:0] cnt,
                              input logic f, input logic e, input logic af,
                              input logic ae, input logic o, input logic u,
                              input logic [7:0] dout);
    vec_t v;
    v.w_en = w; v.r_en = r; v.clr_err = ce; v.din = din; v.cnt = cnt;
    v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ovf = o; v.unf = u;
    v.dout = dout;
    return v;
  endfunction

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [7:0] d);
    bus0.w_en = 1'b1; bus0.data_in = d;
    tick();
    bus0.w_en = 1'b0;
    if (model_q.size() < 8) model_q.push_back(d);
  endtask

  task automatic rd0();
    bus0.r_en = 1'b1;
    tick();
    bus0.r_en = 1'b0;
    if (model_q.size() > 0) exp_d = model_q.pop_front();
  endtask

  initial begin
    rst = 1'b1;
    bus0.flush = 0; bus0.clr_err = 0; bus0.w_en = 0; bus0.r_en = 0;
    bus0.data_in = 8'h00;
    bus1.flush = 0; bus1.clr_err = 0; bus1.w_en = 0; bus1.r_en = 0;
    bus1.data_in = 8'h00;

    //          w  r  ce din    cnt f  e  af ae o  u  dout
    vecs[0]  = mk(1, 0, 0, 8'h10, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 0, 8'h11, 2, 0, 0, 0, 1, 0, 0, 8'h00);
    vecs[2]  = mk(1, 0, 0, 8'h12, 3, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[3]  = mk(1, 0, 0, 8'h13, 4, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[4]  = mk(1, 0, 0, 8'h14, 5, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[5]  = mk(1, 0, 0, 8'h15, 6, 0, 0, 1, 0, 0, 0, 8'h00);
    vecs[6]  = mk(1, 0, 0, 8'h16, 7, 0, 0, 1, 0, 0, 0, 8'h00);
    vecs[7]  = mk(1, 0, 0, 8'h17, 8, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[8]  = mk(1, 0, 0, 8'hFF, 8, 1, 0, 1, 0, 1, 0, 8'h00);
    vecs[9]  = mk(0, 1, 0, 8'h00, 7, 0, 0, 1, 0, 1, 0, 8'h10);
    vecs[10] = mk(0, 1, 0, 8'h00, 6, 0, 0, 1, 0, 1, 0, 8'h11);
    vecs[11] = mk(0, 1, 0, 8'h00, 5, 0, 0, 0, 0, 1, 0, 8'h12);
    vecs[12] = mk(0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 1, 0, 8'h13);
    vecs[13] = mk(0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 1, 0, 8'h14);
    vecs[14] = mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 1, 1, 0, 8'h15);
    vecs[15] = mk(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'h16);
    vecs[16] = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 8'h17);
    vecs[17] = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 1, 1, 8'h17);
    vecs[18] = mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h17);
    vecs[19] = mk(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 8'h17);
    vecs[20] = mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h17);

    tick(); tick();
    rst = 1'b0;

    // Reset state on both instances.
    check("rst_count", 32'(bus0.count), 0);
    check("rst_empty", 32'(bus0.empty), 1);
    check("rst_full", 32'(bus0.full), 0);
    check("rst_ae", 32'(bus0.almost_empty), 1);
    check("rst_af", 32'(bus0.almost_full), 0);
    check("rst_ovf", 32'(bus0.overflow), 0);
    check("rst_unf", 32'(bus0.underflow), 0);
    check("rst_dout", 32'(bus0.data_out), 0);
    check("rst_fwft_empty", 32'(bus1.empty), 1);

    // Table-driven fill, overflow, drain, underflow and error clearing.
    for (int i = 0; i < 21; i++) begin
      bus0.w_en = vecs[i].w_en; bus0.r_en = vecs[i].r_en;
      bus0.clr_err = vecs[i].clr_err; bus0.data_in = vecs[i].din;
      tick();
      check($sformatf("v%0d_count", i), 32'(bus0.count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_full", i), 32'(bus0.full), 32'(vecs[i].full));
      check($sformatf("v%0d_empty", i), 32'(bus0.empty), 32'(vecs[i].empty));
      check($sformatf("v%0d_af", i), 32'(bus0.almost_full), 32'(vecs[i].af));
      check($sformatf("v%0d_ae", i), 32'(bus0.almost_empty), 32'(vecs[i].ae));
      check($sformatf("v%0d_ovf", i), 32'(bus0.overflow), 32'(vecs[i].ovf));
      check($sformatf("v%0d_unf", i), 32'(bus0.underflow), 32'(vecs[i].unf));
      check($sformatf("v%0d_dout", i), 32'(bus0.data_out), 32'(vecs[i].dout));
    end
    bus0.w_en = 0; bus0.r_en = 0; bus0.clr_err = 0;

    // Wrap: fill 5 / drain 5, four rounds, pointers wrap repeatedly.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) begin
        wr0(8'(8'h60 + r * 5 + i));
        check($sformatf("wrap%0d_wcount", r), 32'(bus0.count), 32'(i + 1));
        check($sformatf("wrap%0d_wfull", r), 32'(bus0.full), 0);
        check($sformatf("wrap%0d_wempty", r), 32'(bus0.empty), 0);
      end
      for (int i = 0; i < 5; i++) begin
        rd0();
        check($sformatf("wrap%0d_dout", r), 32'(bus0.data_out), 32'(exp_d));
        check($sformatf("wrap%0d_rempty", r), 32'(bus0.empty),
              (i == 4) ? 32'd1 : 32'd0);
        check($sformatf("wrap%0d_rfull", r), 32'(bus0.full), 0);
      end
    end

    // Streaming: simultaneous read and write at a steady fill of 4.
    for (int i = 0; i < 4; i++) wr0(8'(8'h40 + i));
    for (int i = 0; i < 10; i++) begin
      bus0.w_en = 1'b1; bus0.r_en = 1'b1; bus0.data_in = 8'(8'h44 + i);
      tick();
      model_q.push_back(8'(8'h44 + i));
      exp_d = model_q.pop_front();
      check($sformatf("sim%0d_count", i), 32'(bus0.count), 4);
      check($sformatf("sim%0d_dout", i), 32'(bus0.data_out), 32'(exp_d));
    end
    bus0.w_en = 0; bus0.r_en = 0;
    for (int i = 0; i < 4; i++) begin
      rd0();
      check("sim_drain_dout", 32'(bus0.data_out), 32'(exp_d));
    end
    check("sim_drain_empty", 32'(bus0.empty), 1);

    // Flush at count=5 with overflow set, coincident write dropped.
    for (int i = 0; i < 8; i++) wr0(8'(8'h80 + i));
    wr0(8'hFE);
    check("pre_flush_ovf", 32'(bus0.overflow), 1);
    for (int i = 0; i < 3; i++) rd0();
    check("pre_flush_count", 32'(bus0.count), 5);
    check("pre_flush_dout", 32'(bus0.data_out), 32'h82);
    bus0.flush = 1'b1; bus0.w_en = 1'b1; bus0.data_in = 8'hEE;
    tick();
    bus0.flush = 1'b0; bus0.w_en = 1'b0;
    model_q.delete();
    check("flush_count", 32'(bus0.count), 0);
    check("flush_empty", 32'(bus0.empty), 1);
    check("flush_ovf", 32'(bus0.overflow), 0);
    check("flush_dout", 32'(bus0.data_out), 0);
    bus0.clr_err = 1'b1; bus0.r_en = 1'b1;
    tick();
    bus0.clr_err = 1'b0; bus0.r_en = 1'b0;
    check("clr_vs_unf", 32'(bus0.underflow), 1);
    check("clr_vs_unf_dout", 32'(bus0.data_out), 0);
    wr0(8'h99);
    rd0();
    check("post_flush_dout", 32'(bus0.data_out), 32'h99);
    check("post_flush_empty", 32'(bus0.empty), 1);

    // Fall-through mode: head visible without r_en, pop shows next word.
    bus1.w_en = 1'b1; bus1.data_in = 8'hA5;
    tick();
    bus1.w_en = 1'b0;
    check("fwft_empty0", 32'(bus1.empty), 0);
    check("fwft_head", 32'(bus1.data_out), 32'hA5);
    bus1.w_en = 1'b1; bus1.data_in = 8'h3C;
    tick();
    bus1.w_en = 1'b0;
    check("fwft_head_hold", 32'(bus1.data_out), 32'hA5);
    check("fwft_count2", 32'(bus1.count), 2);
    bus1.r_en = 1'b1;
    tick();
    check("fwft_pop_next", 32'(bus1.data_out), 32'h3C);
    check("fwft_count1", 32'(bus1.count), 1);
    tick();
    bus1.r_en = 1'b0;
    check("fwft_empty1", 32'(bus1.empty), 1);
    check("fwft_unf0", 32'(bus1.underflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised FIFO; successor to the dual-clock FIFO for paths where producer and consumer share one clock.
- Adds fill count, almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Adds a synchronous flush and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a streaming producer and consumer. No pointer synchronisers are needed.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- PTR_WIDTH, 3, address width; DEPTH = 2**PTR_WIDTH.
- DEPTH, 8, number of entries; must equal 2**PTR_WIDTH (elaboration check).
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- flush, input, 1, synchronous clear of pointers, count, data_out register and error flags; memory contents are not cleared.
- clr_err, input, 1, clears overflow and underflow.
- w_en, input, 1, write request.
- data_in, input, DATA_WIDTH, write data.
- r_en, input, 1, read request (pop in FWFT mode).
- data_out, output, DATA_WIDTH, read data.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AF_LEVEL.
- almost_empty, output, 1, count <= AE_LEVEL.
- count, output, PTR_WIDTH+1, number of stored words, 0..DEPTH.
- overflow, output, 1, sticky: a write was attempted while full.
- underflow, output, 1, sticky: a read was attempted while empty.

Behaviour:
- State:
  - wptr and rptr are PTR_WIDTH+1-bit binary pointers.
  - Memory address = low PTR_WIDTH bits of the pointer.
  - count = wptr - rptr, modulo 2**(PTR_WIDTH+1).
- Flag derivation:
  - empty when wptr == rptr.
  - full when the MSBs differ and the low bits are equal.
  - All status flags are decoded from registered pointers only; no input-to-output combinational path.
- Reset (rst=1):
  - wptr = rptr = 0 and data_out = 0.
  - Outputs: count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0), overflow = 0, underflow = 0.
  - rst has priority over flush, clr_err, w_en and r_en.
- flush: same effect as rst on pointers, data_out and error flags; has priority over w_en and r_en in the same cycle.
- Write acceptance:
  - A write is accepted when w_en && !full.
  - mem[waddr] <= data_in and wptr increments.
  - When full, the write is dropped, storage is unchanged, and overflow is set, even if r_en is accepted in the same cycle.
- Read acceptance:
  - A read is accepted when r_en && !empty; rptr increments.
  - When empty, the read is ignored, data_out holds, and underflow is set, even if a write is accepted in the same cycle.
- Simultaneous accepted read and write:
  - Both pointers increment and count is unchanged.
  - Allowed at any fill level 1..DEPTH-1.
- FWFT=0 (standard read):
  - data_out <= mem[raddr] on the accepted-read edge, so data is visible 1 cycle after r_en.
  - data_out holds its value otherwise.
- FWFT=1 (fall-through read):
  - data_out = mem[raddr] combinationally and is valid whenever !empty.
  - An accepted r_en pops the head; the next word appears in the same cycle the pointer updates.
  - First-word latency after a write to an empty FIFO is 1 cycle (empty deasserts on the next edge).
  - data_out is don't-care while empty.
- Error flags:
  - Set on the offending cycle's edge and held until clr_err, flush or rst.
  - If set and clr_err coincide in the same cycle, set wins.
- Wrap-around: pointers wrap naturally modulo 2**(PTR_WIDTH+1); full and empty remain correct across unlimited wraps.

Test Plan:
- Reset, then write 8 words 0x10..0x17 with DEPTH=8:
  - count steps 1..8; almost_full rises after the 6th write; full=1 after the 8th.
  - A 9th write of 0xFF sets overflow=1; count stays 8.
- Read 8 words in FWFT=0 mode:
  - data_out = 0x10..0x17, each 1 cycle after its r_en.
  - almost_empty rises when count reaches 2; empty=1 after the last read.
  - A 9th r_en sets underflow=1 and data_out holds 0x17.
- Wrap test: fill 5, drain 5, repeated 4 times (pointers wrap twice) → data order preserved; full and empty never falsely asserted.
- Simultaneous w_en and r_en at count=4 for 10 cycles → count stays 4; read data equals the words written 4 writes earlier.
- FWFT=1:
  - Write 0xA5 into an empty FIFO → next cycle empty=0 and data_out=0xA5 with no r_en.
  - r_en → empty=1 on the following edge.
- With count=5, overflow=1, assert flush together with w_en → next cycle count=0, empty=1, overflow=0; the write is dropped.
  - Then clr_err asserted while a read-while-empty is attempted → underflow=1.
